// File: rtl/mem_access_stage.sv
// MEM stage of the MIPS-R2000 pipeline: data-memory req/ack access with timeout,
// upstream stall generation, branch resolution and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register,
    input  logic        zero,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        stall,
    output logic        pc_src,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  write_register_wb,
    output logic [1:0]  wb_WB,
    output logic        err_misaligned,
    output logic        bus_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_dmem_req, w_dmem_req_nxt;
    logic                r_dmem_we, w_dmem_we_nxt;
    logic [DATA_W-1:0]   r_dmem_addr, w_dmem_addr_nxt;
    logic [DATA_W-1:0]   r_dmem_wdata, w_dmem_wdata_nxt;
    logic [REG_W-1:0]    r_wr_reg_l, w_wr_reg_l_nxt;
    logic [1:0]          r_wb_l, w_wb_l_nxt;
    logic [DATA_W-1:0]   r_read_data_wb, w_read_data_wb_nxt;
    logic [DATA_W-1:0]   r_alu_res_wb, w_alu_res_wb_nxt;
    logic [REG_W-1:0]    r_write_register_wb, w_write_register_wb_nxt;
    logic [1:0]          r_wb_WB, w_wb_WB_nxt;
    logic                r_err_mis, w_err_mis_nxt;
    logic                r_bus_err, w_bus_err_nxt;

    logic w_access, w_misaligned, w_timeout, w_stall;

    assign w_access     = m_MEM[1] | m_MEM[0];
    assign w_misaligned = (res[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-register values; registers hold unless a case overrides.
    always_comb begin
        w_state_nxt             = r_state;
        w_cnt_nxt               = r_cnt;
        w_dmem_req_nxt          = r_dmem_req;
        w_dmem_we_nxt           = r_dmem_we;
        w_dmem_addr_nxt         = r_dmem_addr;
        w_dmem_wdata_nxt        = r_dmem_wdata;
        w_wr_reg_l_nxt          = r_wr_reg_l;
        w_wb_l_nxt              = r_wb_l;
        w_read_data_wb_nxt      = r_read_data_wb;
        w_alu_res_wb_nxt        = r_alu_res_wb;
        w_write_register_wb_nxt = r_write_register_wb;
        w_wb_WB_nxt             = r_wb_WB;
        w_err_mis_nxt           = 1'b0;
        w_bus_err_nxt           = r_bus_err;
        w_stall                 = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_access || w_misaligned) begin
                    w_read_data_wb_nxt      = w_access ? ERR_RDATA : '0;
                    w_alu_res_wb_nxt        = res;
                    w_write_register_wb_nxt = write_register;
                    w_wb_WB_nxt             = wb_MEM;
                    w_err_mis_nxt           = w_access;
                end else begin
                    w_stall          = 1'b1;
                    w_state_nxt      = S_BUSY;
                    w_cnt_nxt        = '0;
                    w_dmem_req_nxt   = 1'b1;
                    w_dmem_we_nxt    = m_MEM[0];
                    w_dmem_addr_nxt  = {res[DATA_W-1:2], 2'b00};
                    w_dmem_wdata_nxt = write_data_ex;
                    w_wr_reg_l_nxt   = write_register;
                    w_wb_l_nxt       = wb_MEM;
                    w_wb_WB_nxt      = 2'b00;
                end
            end
            S_BUSY: begin
                w_stall = ~(dmem_ack | w_timeout);
                if (dmem_ack || w_timeout) begin
                    // A timeout completes like an ack carrying ERR_RDATA; a real ack wins.
                    w_read_data_wb_nxt      = r_dmem_we ? '0 : (dmem_ack ? dmem_rdata : ERR_RDATA);
                    w_alu_res_wb_nxt        = r_dmem_addr;
                    w_write_register_wb_nxt = r_wr_reg_l;
                    w_wb_WB_nxt             = r_wb_l;
                    w_dmem_req_nxt          = 1'b0;
                    w_state_nxt             = S_IDLE;
                    w_cnt_nxt               = '0;
                    if (!dmem_ack) begin
                        w_bus_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            r_dmem_req          <= 1'b0;
            r_dmem_we           <= 1'b0;
            r_dmem_addr         <= '0;
            r_dmem_wdata        <= '0;
            r_wr_reg_l          <= '0;
            r_wb_l              <= '0;
            r_read_data_wb      <= '0;
            r_alu_res_wb        <= '0;
            r_write_register_wb <= '0;
            r_wb_WB             <= '0;
            r_err_mis           <= 1'b0;
            r_bus_err           <= 1'b0;
        end else begin
            r_state             <= w_state_nxt;
            r_cnt               <= w_cnt_nxt;
            r_dmem_req          <= w_dmem_req_nxt;
            r_dmem_we           <= w_dmem_we_nxt;
            r_dmem_addr         <= w_dmem_addr_nxt;
            r_dmem_wdata        <= w_dmem_wdata_nxt;
            r_wr_reg_l          <= w_wr_reg_l_nxt;
            r_wb_l              <= w_wb_l_nxt;
            r_read_data_wb      <= w_read_data_wb_nxt;
            r_alu_res_wb        <= w_alu_res_wb_nxt;
            r_write_register_wb <= w_write_register_wb_nxt;
            r_wb_WB             <= w_wb_WB_nxt;
            r_err_mis           <= w_err_mis_nxt;
            r_bus_err           <= w_bus_err_nxt;
        end
    end

    // Stall is dropped while reset is held so upstream is not frozen by a dead access.
    assign stall             = w_stall & rst_n;
    assign pc_src            = m_MEM[2] & zero;
    assign dmem_req          = r_dmem_req;
    assign dmem_we           = r_dmem_we;
    assign dmem_addr         = r_dmem_addr;
    assign dmem_wdata        = r_dmem_wdata;
    assign read_data_wb      = r_read_data_wb;
    assign alu_res_wb        = r_alu_res_wb;
    assign write_register_wb = r_write_register_wb;
    assign wb_WB             = r_wb_WB;
    assign err_misaligned    = r_err_mis;
    assign bus_err           = r_bus_err;

endmodule
